// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation pixel store: default geometry, address width and
// the loader state encoding.
package me_pkg;

  localparam int unsigned DEF_MACRO_DIM  = 16;
  localparam int unsigned DEF_SEARCH_DIM = 48;
  localparam int unsigned DEF_PIXEL_W    = 8;
  localparam int unsigned ME_ADDR_W      = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CUR,
    LOAD_SRCH,
    START,
    SERVE
  } loader_state_t;

endpackage

// File: rtl/me_row_ram.sv
// Row store with one write port and one registered read port; reads see pre-write contents and
// out-of-range reads return zero.
module me_row_ram
  import me_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ME_ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ME_ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ME_ADDR_W:0] DepthL = (ME_ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic             raddr_ok;
  logic             waddr_ok;

  assign raddr_ok = {1'b0, raddr} < DepthL;
  assign waddr_ok = {1'b0, waddr} < DepthL;

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we && waddr_ok) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= raddr_ok ? mem[raddr[AW-1:0]] : '0;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/me_window_loader.sv
// Loads a current macroblock and its search window from a row stream, starts the ME controller
// once both are full, and serves rows to its read port until the search completes.
module me_window_loader
  import me_pkg::*;
#(
  parameter int unsigned MACRO_DIM  = DEF_MACRO_DIM,
  parameter int unsigned SEARCH_DIM = DEF_SEARCH_DIM,
  parameter int unsigned PIXEL_W    = DEF_PIXEL_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sof,
  input  logic [SEARCH_DIM*PIXEL_W-1:0] in_row,
  output logic                          me_start,
  input  logic                          me_readyi,
  input  logic                          me_valido,
  input  logic                          ram_en,
  input  logic [ME_ADDR_W-1:0]          ram_addr,
  output logic [MACRO_DIM*PIXEL_W-1:0]  cur_row,
  output logic [SEARCH_DIM*PIXEL_W-1:0] srch_row,
  output logic                          busy
);

  localparam int unsigned CurW = MACRO_DIM * PIXEL_W;
  localparam logic [ME_ADDR_W-1:0] CurLast  = ME_ADDR_W'(MACRO_DIM - 1);
  localparam logic [ME_ADDR_W-1:0] SrchLast = ME_ADDR_W'(SEARCH_DIM - 1);

  loader_state_t        state_q, state_d;
  logic [ME_ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 accept;
  logic                 cur_we, srch_we;
  logic [ME_ADDR_W-1:0] waddr;

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    cur_we   = 1'b0;
    srch_we  = 1'b0;
    waddr    = wr_cnt_q;
    unique case (state_q)
      IDLE: begin
        // Rows arriving without sof are consumed and discarded.
        if (accept && in_sof) begin
          cur_we   = 1'b1;
          waddr    = '0;
          wr_cnt_d = ME_ADDR_W'(1);
          state_d  = LOAD_CUR;
        end
      end
      LOAD_CUR, LOAD_SRCH: begin
        if (accept && in_sof) begin
          cur_we   = 1'b1;
          waddr    = '0;
          wr_cnt_d = ME_ADDR_W'(1);
          state_d  = LOAD_CUR;
        end else if (accept && state_q == LOAD_CUR) begin
          cur_we = 1'b1;
          if (wr_cnt_q == CurLast) begin
            wr_cnt_d = '0;
            state_d  = LOAD_SRCH;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end else if (accept) begin
          srch_we = 1'b1;
          if (wr_cnt_q == SrchLast) begin
            wr_cnt_d = '0;
            state_d  = START;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      START: begin
        if (me_readyi) begin
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (me_valido) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE) || (state_d == LOAD_CUR) || (state_d == LOAD_SRCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign me_start = (state_q == START);
  assign busy     = (state_q != IDLE);

  me_row_ram #(
    .DEPTH (MACRO_DIM),
    .WIDTH (CurW)
  ) u_cur_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (cur_we),
    .waddr (waddr),
    .wdata (in_row[CurW-1:0]),
    .re    (ram_en),
    .raddr (ram_addr),
    .rdata (cur_row)
  );

  me_row_ram #(
    .DEPTH (SEARCH_DIM),
    .WIDTH (SEARCH_DIM * PIXEL_W)
  ) u_srch_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (srch_we),
    .waddr (waddr),
    .wdata (in_row),
    .re    (ram_en),
    .raddr (ram_addr),
    .rdata (srch_row)
  );

endmodule

// File: tb/tb_me_window_loader.sv
// Self-checking bench for me_window_loader: row-model scoreboard for reads, handshake and
// state-visible checks for load, backpressure, resync, completion and reset.
module tb_me_window_loader;
  import me_pkg::*;

  localparam int CW = DEF_MACRO_DIM * DEF_PIXEL_W;
  localparam int SW = DEF_SEARCH_DIM * DEF_PIXEL_W;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_sof;
  logic [SW-1:0] in_row;
  logic          me_start;
  logic          me_readyi;
  logic          me_valido;
  logic          ram_en;
  logic [5:0]    ram_addr;
  logic [CW-1:0] cur_row;
  logic [SW-1:0] srch_row;
  logic          busy;

  me_window_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_row    (in_row),
    .me_start  (me_start),
    .me_readyi (me_readyi),
    .me_valido (me_valido),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .cur_row   (cur_row),
    .srch_row  (srch_row),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0]    cur_m  [DEF_MACRO_DIM];
  logic [SW-1:0]    srch_m [DEF_SEARCH_DIM];
  logic [CW+SW-1:0] sb_q [$];
  logic [CW+SW-1:0] last_exp;

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic sof, input logic [7:0] b);
    in_valid = 1'b1;
    in_sof   = sof;
    in_row   = {DEF_SEARCH_DIM{b}};
    step();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic load_cur(input int idx, input logic [7:0] b, input logic sof);
    cur_m[idx] = {DEF_MACRO_DIM{b}};
    send(sof, b);
  endtask

  task automatic load_srch(input int idx, input logic [7:0] b);
    srch_m[idx] = {DEF_SEARCH_DIM{b}};
    send(1'b0, b);
  endtask

  task automatic compare_out(input string tag);
    logic [CW+SW-1:0] e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_cur"}, SW'(cur_row), SW'(e[CW+SW-1:SW]));
      check({tag, "_srch"}, srch_row, e[SW-1:0]);
    end
  endtask

  task automatic rd(input int a);
    logic [CW-1:0] ec;
    logic [SW-1:0] es;
    ec = '0;
    es = '0;
    if (a < DEF_MACRO_DIM) ec = cur_m[a];
    if (a < DEF_SEARCH_DIM) es = srch_m[a];
    ram_en   = 1'b1;
    ram_addr = 6'(a);
    last_exp = {ec, es};
    sb_q.push_back(last_exp);
    step();
    ram_en = 1'b0;
    compare_out($sformatf("rd%0d", a));
  endtask

  task automatic hold(input int a);
    ram_en   = 1'b0;
    ram_addr = 6'(a);
    sb_q.push_back(last_exp);
    step();
    compare_out($sformatf("hold%0d", a));
  endtask

  // Loads a full window; afterwards the DUT should be in START.
  task automatic full_load(input logic [7:0] cbase, input logic [7:0] sbase);
    for (int r = 0; r < DEF_MACRO_DIM; r++) load_cur(r, cbase + 8'(r), r == 0);
    for (int r = 0; r < DEF_SEARCH_DIM; r++) begin
      if (r == DEF_SEARCH_DIM - 1) check("pre_start", me_start, 1'b0);
      load_srch(r, sbase + 8'(r));
    end
    check("start_hi", me_start, 1'b1);
    check("start_rdy", in_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_row = '0;
    me_readyi = 1'b0; me_valido = 1'b0; ram_en = 1'b0; ram_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 1'b0);
    check("rst_start", me_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cur", SW'(cur_row), '0);
    check("rst_srch", srch_row, '0);
    rst = 1'b0;
    step();
    check("idle_ready", in_ready, 1'b1);

    // Full load, row r = byte r, controller ready at once.
    me_readyi = 1'b1;
    full_load(8'h00, 8'h00);
    step();
    check("serve_start", me_start, 1'b0);
    check("serve_busy", busy, 1'b1);
    check("serve_ready", in_ready, 1'b0);
    rd(5);
    check("cur5_const", SW'(cur_row), SW'({DEF_MACRO_DIM{8'h05}}));
    hold(9);
    rd(47);
    check("srch47_const", srch_row, {DEF_SEARCH_DIM{8'h2F}});
    rd(16);
    rd(50);
    me_valido = 1'b1;
    step();
    me_valido = 1'b0;
    check("done_busy", busy, 1'b0);
    check("done_ready", in_ready, 1'b1);

    // Backpressure in START.
    me_readyi = 1'b0;
    full_load(8'h10, 8'h60);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_start%0d", i), me_start, 1'b1);
      check($sformatf("bp_ready%0d", i), in_ready, 1'b0);
      step();
    end
    me_readyi = 1'b1;
    check("bp_accept_cycle", me_start, 1'b1);
    step();
    check("bp_accepted", me_start, 1'b0);
    rd(3);
    rd(40);
    me_valido = 1'b1;
    step();
    me_valido = 1'b0;

    // Resync on search row 20, plus a stray valido during LOAD_SRCH.
    for (int r = 0; r < DEF_MACRO_DIM; r++) load_cur(r, 8'h20 + 8'(r), r == 0);
    for (int r = 0; r < 20; r++) load_srch(r, 8'h30 + 8'(r));
    load_cur(0, 8'hA0, 1'b1);
    check("resync_busy", busy, 1'b1);
    check("resync_ready", in_ready, 1'b1);
    check("resync_wr_cnt", SW'(dut.wr_cnt_q), SW'(1));
    for (int r = 1; r < DEF_MACRO_DIM; r++) load_cur(r, 8'h80 + 8'(r), 1'b0);
    for (int r = 0; r < 10; r++) load_srch(r, 8'h40 + 8'(r));
    me_valido = 1'b1;
    step();
    me_valido = 1'b0;
    check("valido_ign_busy", busy, 1'b1);
    check("valido_ign_ready", in_ready, 1'b1);
    for (int r = 10; r < DEF_SEARCH_DIM; r++) begin
      if (r == DEF_SEARCH_DIM - 1) check("rs_pre_start", me_start, 1'b0);
      load_srch(r, 8'h40 + 8'(r));
    end
    check("rs_start", me_start, 1'b1);
    step();
    rd(0);
    rd(15);
    rd(20);
    me_valido = 1'b1;
    step();
    me_valido = 1'b0;

    // Reset mid-LOAD_SRCH after 30 search rows.
    for (int r = 0; r < DEF_MACRO_DIM; r++) load_cur(r, 8'hC0 + 8'(r), r == 0);
    for (int r = 0; r < 30; r++) load_srch(r, 8'h50 + 8'(r));
    check("pre_rst_wr_cnt", SW'(dut.wr_cnt_q), SW'(30));
    rd(4);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_start", me_start, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_cur", SW'(cur_row), '0);
    check("mid_rst_srch", srch_row, '0);
    step();
    rst = 1'b0;
    step();
    for (int r = 0; r < 5; r++) send(1'b0, 8'(r));
    check("drop_busy", busy, 1'b0);
    check("drop_ready", in_ready, 1'b1);
    send(1'b1, 8'hEE);
    check("sof_busy", busy, 1'b1);
    check("sof_wr_cnt", SW'(dut.wr_cnt_q), SW'(1));

    check("sb_drained", SW'(sb_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
